uart_tx_frame_seq: RTL and testbench

Controller that sequences readout of one packed edge-image frame from the TX frame RAM into the UART TX FIFO, wrapping the payload in a fixed packet: sync header, frame ID, length, payload and checksum. It sits between the pixel packer / frame RAM and the UART TX FIFO. It owns the RAM read port and the FIFO push port, and applies backpressure from the FIFO full flag. The plotter host uses the packet framing to resynchronise and to detect corrupted or dropped frames.

---
 rtl/uart_tx_pkg.sv | 36 +++
 rtl/uart_tx_frame_seq_if.sv | 43 ++++
 rtl/uart_tx_frame_seq.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_frame_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_pkg
//  Purpose  : Shared types and constants for the UART TX frame path
//             (frame sequencer, TX frame RAM, pixel packer).
//  Contents : tx_seq_state_e  - sequencer state encoding
//             SYNC0_DEF/SYNC1_DEF - default packet sync header bytes
//             FRAME_BYTES     - packed payload bytes per edge-image frame
//             addr_width()    - RAM address width for a given byte count
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    HDR0  = 4'd1,
    HDR1  = 4'd2,
    ID    = 4'd3,
    LEN_H = 4'd4,
    LEN_L = 4'd5,
    RD    = 4'd6,
    WR    = 4'd7,
    CSUM  = 4'd8
  } tx_seq_state_e;

  localparam logic [7:0] SYNC0_DEF   = 8'hA5;
  localparam logic [7:0] SYNC1_DEF   = 8'h5A;
  localparam int         FRAME_BYTES = 5280;

  // A one-byte frame still needs a 1-bit address bus.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_frame_seq_if
//  Purpose  : Bundles the frame-RAM read port and the TX FIFO push port
//             driven by the frame sequencer.
//  Signals  : ram_re, ram_addr  - RAM read request (sequencer -> RAM)
//             ram_rdata         - RAM read data, valid 1 cycle after ram_re
//             fifo_full         - TX FIFO full (FIFO -> sequencer)
//             fifo_push, fifo_data - FIFO push strobe and byte
//  Modports : master - sequencer side, slave - RAM/FIFO side
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_seq_if #(
  parameter int ADDR_W = 13
) ();

  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;
  logic              fifo_full;
  logic              fifo_push;
  logic [7:0]        fifo_data;

  modport master (
    output ram_re,
    output ram_addr,
    input  ram_rdata,
    input  fifo_full,
    output fifo_push,
    output fifo_data
  );

  modport slave (
    input  ram_re,
    input  ram_addr,
    output ram_rdata,
    output fifo_full,
    input  fifo_push,
    input  fifo_data
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_frame_seq
//  Purpose  : Reads one packed frame out of the TX frame RAM and pushes it
//             into the UART TX FIFO as a packet:
//             SYNC0, SYNC1, frame ID, LEN_H, LEN_L, payload, checksum.
//  Ports    : clk, reset    - clock, synchronous active-high reset
//             enable        - gate for accepting new frames
//             frame_tick    - pulse: frame RAM holds a complete frame
//             bus (master)  - RAM read port and FIFO push port
//             busy, done    - packet in flight / packet finished pulse
//             frame_id      - ID of the current or last packet
//             drop_cnt      - saturating count of rejected frame_ticks
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame_seq
  import uart_tx_pkg::*;
#(
  parameter int         NUM_BYTES = FRAME_BYTES,
  parameter logic [7:0] SYNC0     = SYNC0_DEF,
  parameter logic [7:0] SYNC1     = SYNC1_DEF
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             enable,
  input  wire logic             frame_tick,
  uart_tx_frame_seq_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            frame_id,
  output logic [7:0]            drop_cnt
);

  localparam int                ADDR_W    = addr_width(NUM_BYTES);
  localparam logic [15:0]       C_LEN     = 16'(NUM_BYTES);
  localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(NUM_BYTES - 1);

  tx_seq_state_e     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_sum;
  logic [7:0]        r_byte;
  logic              r_wr_first;
  logic [7:0]        r_frame_id;
  logic [7:0]        r_drop_cnt;
  logic              r_ram_re;
  logic              r_busy;
  logic              r_done;

  logic              w_emit;
  logic              w_push;
  logic              w_accept;
  logic              w_reject;
  logic [7:0]        w_byte;

  always_comb begin
    w_emit = 1'b0;
    case (r_state)
      HDR0, HDR1, ID, LEN_H, LEN_L, WR, CSUM: w_emit = 1'b1;
      default:                                w_emit = 1'b0;
    endcase
  end

  assign w_push   = w_emit & ~bus.fifo_full;
  assign w_accept = (r_state == IDLE) & enable & frame_tick;
  assign w_reject = frame_tick & ~w_accept;

  // The RAM's registered read data lands in the first WR cycle, so that
  // cycle takes it straight from the RAM output while r_byte latches it;
  // any stall cycles after that replay r_byte, independent of what the RAM
  // drives once ram_re has dropped.
  assign w_byte = (r_state == WR && r_wr_first) ? bus.ram_rdata : r_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_sum      <= 8'h00;
      r_byte     <= 8'h00;
      r_wr_first <= 1'b0;
      r_frame_id <= 8'h00;
      r_drop_cnt <= 8'h00;
      r_ram_re   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_ram_re <= 1'b0;

      if (w_reject && r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end

      // r_byte is always preloaded with the byte the next state will emit.
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= HDR0;
            r_frame_id <= r_frame_id + 8'd1;
            r_addr     <= '0;
            r_sum      <= 8'h00;
            r_byte     <= SYNC0;
            r_busy     <= 1'b1;
          end
        end
        HDR0: begin
          if (w_push) begin
            r_state <= HDR1;
            r_byte  <= SYNC1;
          end
        end
        HDR1: begin
          if (w_push) begin
            r_state <= ID;
            r_byte  <= r_frame_id;
          end
        end
        ID: begin
          if (w_push) begin
            r_state <= LEN_H;
            r_byte  <= C_LEN[15:8];
          end
        end
        LEN_H: begin
          if (w_push) begin
            r_state <= LEN_L;
            r_byte  <= C_LEN[7:0];
          end
        end
        LEN_L: begin
          if (w_push) begin
            r_state  <= RD;
            r_ram_re <= 1'b1;
          end
        end
        RD: begin
          r_state    <= WR;
          r_wr_first <= 1'b1;
        end
        WR: begin
          r_wr_first <= 1'b0;
          r_byte     <= w_byte;
          if (w_push) begin
            r_sum <= r_sum + w_byte;
            if (r_addr == C_LAST) begin
              r_state <= CSUM;
              r_byte  <= r_sum + w_byte;
            end else begin
              r_state  <= RD;
              r_addr   <= r_addr + ADDR_W'(1);
              r_ram_re <= 1'b1;
            end
          end
        end
        CSUM: begin
          if (w_push) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_re    = r_ram_re;
  assign bus.ram_addr  = r_addr;
  assign bus.fifo_push = w_push;
  assign bus.fifo_data = w_byte;
  assign busy          = r_busy;
  assign done          = r_done;
  assign frame_id      = r_frame_id;
  assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_frame_seq
//  Purpose  : Directed self-checking bench for uart_tx_frame_seq. A 4-byte
//             instance covers framing, stalls, drops, enable, reset and ID
//             wrap; a full-size instance covers length, checksum and
//             address range.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- small instance: NUM_BYTES = 4 ----------------
  logic       enable_s = 1'b1;
  logic       tick_s   = 1'b0;
  logic       busy_s, done_s;
  logic [7:0] fid_s, drop_s;
  uart_tx_frame_seq_if #(.ADDR_W(2)) bus_s ();

  uart_tx_frame_seq #(.NUM_BYTES(4)) dut_s (
    .clk(clk), .reset(reset), .enable(enable_s), .frame_tick(tick_s),
    .bus(bus_s), .busy(busy_s), .done(done_s), .frame_id(fid_s), .drop_cnt(drop_s)
  );

  logic [7:0] mem_s [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  // Read data is valid only in the cycle after ram_re; otherwise junk.
  always @(posedge clk) bus_s.ram_rdata <= bus_s.ram_re ? mem_s[bus_s.ram_addr] : 8'hEE;

  logic [7:0] log_d [$];
  int         log_c [$];
  int         done_cyc_s = -1;
  int         viol_s = 0;
  int         t0 = 0;

  always @(negedge clk) begin
    if (bus_s.fifo_push) begin
      log_d.push_back(bus_s.fifo_data);
      log_c.push_back(cyc);
      if (bus_s.fifo_full) viol_s++;
    end
    if (done_s) done_cyc_s = cyc;
  end

  // ---------------- large instance: NUM_BYTES = 5280 ----------------
  logic       enable_l = 1'b1;
  logic       tick_l   = 1'b0;
  logic       busy_l, done_l;
  logic [7:0] fid_l, drop_l;
  uart_tx_frame_seq_if #(.ADDR_W(13)) bus_l ();

  uart_tx_frame_seq #(.NUM_BYTES(5280)) dut_l (
    .clk(clk), .reset(reset), .enable(enable_l), .frame_tick(tick_l),
    .bus(bus_l), .busy(busy_l), .done(done_l), .frame_id(fid_l), .drop_cnt(drop_l)
  );

  always @(posedge clk) bus_l.ram_rdata <= bus_l.ram_re ? 8'hFF : 8'h00;

  int         cnt_l = 0;
  int         rd_cnt_l = 0;
  int         max_addr_l = 0;
  int         done_cyc_l = -1;
  logic [7:0] hdr_l [5];
  logic [7:0] last_l = 8'h00;

  always @(negedge clk) begin
    if (bus_l.fifo_push) begin
      if (cnt_l < 5) hdr_l[cnt_l] = bus_l.fifo_data;
      last_l = bus_l.fifo_data;
      cnt_l++;
    end
    if (bus_l.ram_re) begin
      rd_cnt_l++;
      if (int'(bus_l.ram_addr) > max_addr_l) max_addr_l = int'(bus_l.ram_addr);
    end
    if (done_l) done_cyc_l = cyc;
  end

  // One small-instance packet: tick in the first cycle, then per-cycle
  // drive of fifo_full, extra ticks and enable up to end_rel. Returns just
  // after the negedge of cycle end_rel so that cycle's push is logged.
  task automatic run_small(input int end_rel, input int full_from, input int full_n,
                           input int tk_a, input int tk_b, input int en_off_at);
    @(posedge clk); #1;
    log_d.delete();
    log_c.delete();
    done_cyc_s = -1;
    enable_s   = 1'b1;
    tick_s     = 1'b1;
    t0         = cyc;
    #5;
    for (int rel = 1; rel <= end_rel; rel++) begin
      @(posedge clk); #1;
      bus_s.fifo_full = (rel >= full_from && rel < full_from + full_n);
      tick_s          = (rel == tk_a || rel == tk_b);
      enable_s        = (en_off_at < 0 || rel < en_off_at);
      #5;
    end
  endtask

  // Expected packet: header, payload 01..04, checksum 0A. A stall of n
  // cycles in front of list entry stall_idx shifts it and all later entries.
  task automatic check_pkt(input string nm, input logic [7:0] id, input int stall_idx,
                           input int stall_n, input bit chk_done);
    logic [7:0] exp_d [10];
    int         exp_o [10];
    int         n;
    exp_d = '{8'hA5, 8'h5A, id, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    exp_o = '{1, 2, 3, 4, 5, 7, 9, 11, 13, 14};
    for (int i = stall_idx; i < 10; i++) exp_o[i] += stall_n;
    check_eq({nm, "_count"}, log_d.size(), 10);
    n = (log_d.size() < 10) ? log_d.size() : 10;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_byte%0d", nm, i), log_d[i], exp_d[i]);
      check_eq($sformatf("%s_cyc%0d", nm, i), log_c[i] - t0, exp_o[i]);
    end
    if (chk_done) check_eq({nm, "_done_cyc"}, done_cyc_s - t0, 15 + stall_n);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_s.fifo_full = 1'b0;
    bus_l.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #5;
    check_eq("rst_push",  bus_s.fifo_push, 0);
    check_eq("rst_ram_re", bus_s.ram_re, 0);
    check_eq("rst_busy",  busy_s, 0);
    check_eq("rst_done",  done_s, 0);
    check_eq("rst_fid",   fid_s, 0);
    check_eq("rst_drop",  drop_s, 0);

    // Full-size frame: length bytes, checksum, address range, latency.
    @(posedge clk); #1;
    tick_l = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    tick_l = 1'b0;
    for (int i = 0; i < 11000 && done_cyc_l < 0; i++) @(posedge clk);
    #6;
    check_eq("big_done_seen", (done_cyc_l >= 0), 1);
    check_eq("big_done_cyc", done_cyc_l - t0, 10567);
    check_eq("big_count", cnt_l, 5286);
    check_eq("big_sync0", hdr_l[0], 8'hA5);
    check_eq("big_sync1", hdr_l[1], 8'h5A);
    check_eq("big_id", hdr_l[2], 8'h01);
    check_eq("big_len_h", hdr_l[3], 8'h14);
    check_eq("big_len_l", hdr_l[4], 8'hA0);
    check_eq("big_csum", last_l, 8'h60);
    check_eq("big_max_addr", max_addr_l, 5279);
    check_eq("big_reads", rd_cnt_l, 5280);

    // Basic packet, no backpressure.
    run_small(20, 0, 0, -1, -1, -1);
    check_pkt("pkt1", 8'h01, 10, 0, 1);

    // Three full cycles in front of payload byte 2 (list entry 7).
    run_small(20, 11, 3, -1, -1, -1);
    check_pkt("stall", 8'h02, 7, 3, 1);
    check_eq("stall_no_push_full", viol_s, 0);

    // Ticks during payload and in the CSUM push cycle are dropped; the
    // tick in the done cycle starts the next packet.
    run_small(14, 0, 0, 8, 14, -1);
    check_pkt("drops", 8'h03, 10, 0, 0);
    run_small(20, 0, 0, -1, -1, -1);
    check_pkt("done_tick", 8'h04, 10, 0, 1);
    check_eq("drop_cnt2", drop_s, 2);

    // Disabled tick: no packet, counted as a drop.
    @(posedge clk); #1;
    log_d.delete();
    log_c.delete();
    enable_s = 1'b0;
    tick_s   = 1'b1;
    @(posedge clk); #1;
    tick_s = 1'b0;
    repeat (5) @(posedge clk);
    #6;
    check_eq("dis_pushes", log_d.size(), 0);
    check_eq("dis_drop", drop_s, 3);
    check_eq("dis_busy", busy_s, 0);
    check_eq("dis_fid", fid_s, 4);

    // Enable removed mid-packet: packet still completes.
    run_small(20, 0, 0, -1, -1, 3);
    check_pkt("en_off", 8'h05, 10, 0, 1);
    enable_s = 1'b1;

    // Reset in the cycle payload byte 2 is being pushed.
    run_small(10, 0, 0, -1, -1, -1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #5;
    check_eq("mrst_push", bus_s.fifo_push, 0);
    check_eq("mrst_busy", busy_s, 0);
    check_eq("mrst_ram_re", bus_s.ram_re, 0);
    check_eq("mrst_fid", fid_s, 0);
    check_eq("mrst_drop", drop_s, 0);
    run_small(20, 0, 0, -1, -1, -1);
    check_pkt("after_rst", 8'h01, 10, 0, 1);

    // 255 more frames wrap frame_id back to 00.
    for (int k = 0; k < 255; k++) run_small(15, 0, 0, -1, -1, -1);
    check_pkt("wrap", 8'h00, 10, 0, 1);
    check_eq("wrap_fid", fid_s, 0);
    check_eq("wrap_drop", drop_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
